// File: rtl/fp_addsub_axis.sv
// Three-stage pipelined floating-point adder/subtractor with joined AXI-Stream operands.
// Stages: unpack/align, magnitude add/sub, normalise/round/pack.
module fp_addsub_axis #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_axis_a_tvalid,
  output logic         s_axis_a_tready,
  input  logic [W-1:0] s_axis_a_tdata,
  input  logic         s_axis_a_tuser,
  input  logic         s_axis_b_tvalid,
  output logic         s_axis_b_tready,
  input  logic [W-1:0] s_axis_b_tdata,
  output logic         m_axis_result_tvalid,
  input  logic         m_axis_result_tready,
  output logic [W-1:0] m_axis_result_tdata,
  output logic [2:0]   m_axis_result_tuser
);

  localparam int F       = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic             zsign;
    logic [EXP_W-1:0] exp;
    logic             spec;
    logic [2:0]       spec_flags;
    logic [W-1:0]     spec_word;
  } ctl_t;

  logic advance, in_fire;
  assign advance         = !m_axis_result_tvalid || m_axis_result_tready;
  assign in_fire         = aresetn && advance && s_axis_a_tvalid && s_axis_b_tvalid;
  assign s_axis_a_tready = in_fire;
  assign s_axis_b_tready = in_fire;

  // Stage 1: unpack, flush subnormals, order by magnitude, align the smaller operand
  logic             sa, sb, sx, sy, swap;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] ea, eb, ex, ey, diff;
  logic [MAN_W:0]   ha, hb, hx, hy;
  logic [F-1:0]     y_ext, y_al;
  ctl_t             c1;

  assign sa = s_axis_a_tdata[W-1];
  assign sb = s_axis_b_tdata[W-1] ^ s_axis_a_tuser;
  assign ea = s_axis_a_tdata[W-2:MAN_W];
  assign eb = s_axis_b_tdata[W-2:MAN_W];

  // NOTE: every variable written in always_comb gets a default on every path, or a latch is inferred.
  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (&ea) && (|s_axis_a_tdata[MAN_W-1:0]);
    b_nan  = (&eb) && (|s_axis_b_tdata[MAN_W-1:0]);
    a_inf  = (&ea) && !(|s_axis_a_tdata[MAN_W-1:0]);
    b_inf  = (&eb) && !(|s_axis_b_tdata[MAN_W-1:0]);
    ha     = a_zero ? '0 : {1'b1, s_axis_a_tdata[MAN_W-1:0]};
    hb     = b_zero ? '0 : {1'b1, s_axis_b_tdata[MAN_W-1:0]};
    swap   = {eb, hb} > {ea, ha};
    sx     = swap ? sb : sa;
    sy     = swap ? sa : sb;
    ex     = swap ? eb : ea;
    ey     = swap ? ea : eb;
    hx     = swap ? hb : ha;
    hy     = swap ? ha : hb;
    diff   = ex - ey;
    y_ext  = {hy, 3'b000};
    if (32'(diff) >= MAN_W + 3)
      y_al = {{(F-1){1'b0}}, |hy};
    else
      y_al = (y_ext >> diff) | {{(F-1){1'b0}}, |(y_ext & ~({F{1'b1}} << diff))};

    c1       = '0;
    c1.sign  = sx;
    c1.zsign = sx & sy;  // only (-0)+(-0) keeps a negative zero
    c1.exp   = ex;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      c1.spec       = 1'b1;
      c1.spec_word  = QNAN;
      c1.spec_flags = 3'b100;
    end else if (a_inf) begin
      c1.spec      = 1'b1;
      c1.spec_word = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      c1.spec      = 1'b1;
      c1.spec_word = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic         s1_valid, s1_sub;
  ctl_t         s1_ctl;
  logic [F-1:0] s1_mx, s1_my;

  // Stage 2: |X| >= |Y| after alignment, so the difference never goes negative
  logic [F:0] sum_d;
  assign sum_d = s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});

  logic       s2_valid;
  ctl_t       s2_ctl;
  logic [F:0] s2_sum;

  // Stage 3: normalise, round to nearest even, pack and classify
  int               lzc, exp_i;
  logic [F-1:0]     norm;
  logic             round_up;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res_word;
  logic [2:0]       res_flags;

  always_comb begin
    lzc = F;
    for (int i = 0; i < F; i++)
      if (s2_sum[i]) lzc = F - 1 - i;
    if (s2_sum[F]) begin
      norm  = {s2_sum[F:2], s2_sum[1] | s2_sum[0]};
      exp_i = int'(s2_ctl.exp) + 1;
    end else begin
      norm  = s2_sum[F-1:0] << lzc;
      exp_i = int'(s2_ctl.exp) - lzc;
    end
    round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r   = {1'b0, norm[F-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    frac     = mant_r[MAN_W-1:0];
    if (mant_r[MAN_W+1]) begin
      exp_i = exp_i + 1;
      frac  = mant_r[MAN_W:1];
    end

    res_flags = 3'b000;
    if (s2_ctl.spec) begin
      res_word  = s2_ctl.spec_word;
      res_flags = s2_ctl.spec_flags;
    end else if (s2_sum == '0) begin
      res_word = {s2_ctl.zsign, {(W-1){1'b0}}};
    end else if (exp_i >= EXP_MAX) begin
      res_word  = {s2_ctl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_flags = 3'b010;
    end else if (exp_i <= 0) begin
      res_word  = {s2_ctl.sign, {(W-1){1'b0}}};
      res_flags = 3'b001;
    end else begin
      res_word = {s2_ctl.sign, EXP_W'(exp_i), frac};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid             <= 1'b0;
      s1_sub               <= 1'b0;
      s1_ctl               <= '0;
      s1_mx                <= '0;
      s1_my                <= '0;
      s2_valid             <= 1'b0;
      s2_ctl               <= '0;
      s2_sum               <= '0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
      m_axis_result_tuser  <= '0;
    end else if (advance) begin
      s1_valid             <= in_fire;
      s1_sub               <= sx ^ sy;
      s1_ctl               <= c1;
      s1_mx                <= {hx, 3'b000};
      s1_my                <= y_al;
      s2_valid             <= s1_valid;
      s2_ctl               <= s1_ctl;
      s2_sum               <= sum_d;
      m_axis_result_tvalid <= s2_valid;
      m_axis_result_tdata  <= res_word;
      m_axis_result_tuser  <= res_flags;
    end
  end

endmodule

// File: tb/tb_fp_addsub_axis.sv
// Directed self-checking bench for fp_addsub_axis (binary32 configuration).
module tb_fp_addsub_axis;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        a_tvalid = 1'b0, a_tready, a_tuser = 1'b0;
  logic [31:0] a_tdata = '0;
  logic        b_tvalid = 1'b0, b_tready;
  logic [31:0] b_tdata = '0;
  logic        m_tvalid, m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic [2:0]  m_tuser;

  int checks = 0;
  int errors = 0;

  fp_addsub_axis #(.EXP_W(8), .MAN_W(23)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tvalid      (a_tvalid),
    .s_axis_a_tready      (a_tready),
    .s_axis_a_tdata       (a_tdata),
    .s_axis_a_tuser       (a_tuser),
    .s_axis_b_tvalid      (b_tvalid),
    .s_axis_b_tready      (b_tready),
    .s_axis_b_tdata       (b_tdata),
    .m_axis_result_tvalid (m_tvalid),
    .m_axis_result_tready (m_tready),
    .m_axis_result_tdata  (m_tdata),
    .m_axis_result_tuser  (m_tuser)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stream vectors: 64+64, 32+32, 16+16, 8+8, 4+4, 2+2, 4+0, 8-4, 1+3, 5+(-1)
  localparam logic [31:0] SA [10] = '{32'h42800000, 32'h42000000, 32'h41800000, 32'h41000000,
                                      32'h40800000, 32'h40000000, 32'h40800000, 32'h41000000,
                                      32'h3F800000, 32'h40A00000};
  localparam logic [31:0] SB [10] = '{32'h42800000, 32'h42000000, 32'h41800000, 32'h41000000,
                                      32'h40800000, 32'h40000000, 32'h00000000, 32'h40800000,
                                      32'h40400000, 32'hBF800000};
  localparam logic        SOP [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] SEXP [10] = '{32'h43000000, 32'h42800000, 32'h42000000, 32'h41800000,
                                        32'h41000000, 32'h40800000, 32'h40800000, 32'h40800000,
                                        32'h40800000, 32'h40800000};

  logic [31:0] got [16];

  // One operation: present operands, wait for accept, then wait for the result beat.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                       output logic [31:0] res, output logic [2:0] flg, output int lat, output bit ok);
    int wait_cyc;
    ok = 1'b0; lat = 0; res = '0; flg = '0;
    @(negedge aclk);
    a_tdata = a; b_tdata = b; a_tuser = op;
    a_tvalid = 1'b1; b_tvalid = 1'b1; m_tready = 1'b1;
    #1;
    wait_cyc = 0;
    while (!a_tready && wait_cyc < 20) begin
      @(negedge aclk); #1; wait_cyc++;
    end
    if (!a_tready) begin
      a_tvalid = 1'b0; b_tvalid = 1'b0;
      return;
    end
    @(negedge aclk);
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    lat = 1;
    while (!m_tvalid && lat < 20) begin
      @(negedge aclk); lat++;
    end
    if (m_tvalid) begin
      ok = 1'b1; res = m_tdata; flg = m_tuser;
    end
  endtask

  // Drive the 10 stream vectors for a fixed window, logging outputs and stall behaviour.
  task automatic stream_beats(input bit toggle, output int n_out, output int first_cyc,
                              output int last_cyc, output int hold_err, output int ready_err);
    int idx = 0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    n_out = 0; first_cyc = -1; last_cyc = -1; hold_err = 0; ready_err = 0;
    for (int k = 0; k < 16; k++) got[k] = '0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge aclk);
      if (stalled && (!m_tvalid || m_tdata !== held)) hold_err++;
      m_tready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (idx < 10) begin
        a_tvalid = 1'b1; b_tvalid = 1'b1;
        a_tdata = SA[idx]; b_tdata = SB[idx]; a_tuser = SOP[idx];
      end else begin
        a_tvalid = 1'b0; b_tvalid = 1'b0;
      end
      #1;
      if (m_tvalid && m_tready) begin
        if (n_out < 16) got[n_out] = m_tdata;
        if (n_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_out++;
      end
      stalled = m_tvalid && !m_tready;
      held = m_tdata;
      if (stalled && (a_tready || b_tready)) ready_err++;
      if (a_tready) idx++;
    end
    m_tready = 1'b1;
  endtask

  task automatic test_reset();
    #1 aresetn = 1'b0;
    a_tvalid = 1'b1; b_tvalid = 1'b1; a_tdata = 32'h3F800000; b_tdata = 32'h3F800000;
    repeat (3) @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 00000000", m_tdata); end
    checks++; if (m_tuser !== 3'b000) begin errors++; $display("FAIL reset_tuser got %b want 000", m_tuser); end
    checks++; if (a_tready !== 1'b0) begin errors++; $display("FAIL reset_a_tready got %b want 0", a_tready); end
    checks++; if (b_tready !== 1'b0) begin errors++; $display("FAIL reset_b_tready got %b want 0", b_tready); end
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    @(negedge aclk) aresetn = 1'b1;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_latency();
    logic [31:0] res; logic [2:0] flg; int lat; bit ok;
    do_op(32'h42800000, 32'h42800000, 1'b0, res, flg, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL latency_timeout no result beat"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL latency got %0d want 3", lat); end
    checks++; if (res !== 32'h43000000) begin errors++; $display("FAIL latency_data got %h want 43000000", res); end
    checks++; if (flg !== 3'b000) begin errors++; $display("FAIL latency_flags got %b want 000", flg); end
  endtask

  task automatic test_back_to_back();
    int n, f, l, he, re;
    stream_beats(1'b0, n, f, l, he, re);
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", n); end
    checks++; if (l - f != 9) begin errors++; $display("FAIL b2b_consecutive got span %0d want 9", l - f); end
    checks++; if (f != 3) begin errors++; $display("FAIL b2b_first_cycle got %0d want 3", f); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== SEXP[i]) begin errors++; $display("FAIL b2b_beat%0d got %h want %h", i, got[i], SEXP[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n, f, l, he, re;
    stream_beats(1'b1, n, f, l, he, re);
    checks++; if (n != 10) begin errors++; $display("FAIL bp_count got %0d want 10", n); end
    checks++; if (he != 0) begin errors++; $display("FAIL bp_hold got %0d unstable stalls want 0", he); end
    checks++; if (re != 0) begin errors++; $display("FAIL bp_s_tready got %0d stalled-ready cycles want 0", re); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== SEXP[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, got[i], SEXP[i]); end
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  task automatic test_specials();
    vec_t v [11];
    logic [31:0] res; logic [2:0] flg; int lat; bit ok;
    v[0]  = '{32'h40800000, 32'h40800000, 1'b1, 32'h00000000, 3'b000}; // 4-4 -> +0
    v[1]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000}; // tie, even stays
    v[2]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010}; // overflow
    v[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100}; // inf-inf
    v[4]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100}; // NaN in
    v[5]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000}; // -0 + -0
    v[6]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000}; // -inf + 1
    v[7]  = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001}; // underflow
    v[8]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000}; // subnormal flushed
    v[9]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000}; // above half: up
    v[10] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000}; // tie, odd rounds up
    for (int i = 0; i < 11; i++) begin
      do_op(v[i].a, v[i].b, v[i].op, res, flg, lat, ok);
      checks++;
      if (!ok || res !== v[i].res) begin
        errors++; $display("FAIL special%0d_data got %h want %h (beat seen %0d)", i, res, v[i].res, ok);
      end
      checks++;
      if (flg !== v[i].flg) begin errors++; $display("FAIL special%0d_flags got %b want %b", i, flg, v[i].flg); end
    end
  endtask

  task automatic test_join();
    int bad_ready = 0, bad_valid = 0;
    @(negedge aclk);
    a_tvalid = 1'b1; b_tvalid = 1'b0; a_tdata = 32'h3F800000; b_tdata = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (a_tready || b_tready) bad_ready++;
      @(negedge aclk);
    end
    a_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_tvalid) bad_valid++;
      @(negedge aclk);
    end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL join_ready got %0d ready cycles want 0", bad_ready); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL join_no_result got %0d valid cycles want 0", bad_valid); end
  endtask

  task automatic test_reset_inflight();
    int stale = 0;
    logic [31:0] res; logic [2:0] flg; int lat; bit ok;
    @(negedge aclk);
    m_tready = 1'b0;
    a_tvalid = 1'b1; b_tvalid = 1'b1; a_tuser = 1'b0;
    a_tdata = 32'h40000000; b_tdata = 32'h40000000;
    @(negedge aclk);
    a_tdata = 32'h41000000; b_tdata = 32'h41000000;
    @(negedge aclk);
    a_tvalid = 1'b0; b_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL inflight_pre got tvalid %b want 1", m_tvalid); end
    aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL inflight_reset got tvalid %b want 0", m_tvalid); end
    @(negedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (m_tvalid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL inflight_stale got %0d beats want 0", stale); end
    do_op(32'h40000000, 32'h40000000, 1'b0, res, flg, lat, ok);
    checks++; if (!ok || res !== 32'h40800000) begin errors++; $display("FAIL inflight_recover got %h want 40800000", res); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_specials();
    test_join();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
